// File: rtl/dotproduct_16_scheduler_pkg.sv
// Shared constants and helpers for the 16-lane dot-product scheduler.
package dotproduct_16_scheduler_pkg;

    localparam int LANES = 16;

    // Engine result width for a given signed operand width.
    function automatic int dp_width(input int in_width);
        return 2 * in_width + 4;
    endfunction

    // Bits needed to name one requester; never narrower than one bit.
    function automatic int tag_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } sched_state_e;

endpackage

// File: rtl/dotproduct_16_scheduler_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each in-flight operation.
module dp_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/dotproduct_16_scheduler.sv
// Round-robin scheduler sharing one 16-lane dot-product engine among requesters,
// routing in-order results back to their owners via a tag FIFO.
module dotproduct_16_scheduler
    import dotproduct_16_scheduler_pkg::*;
#(
    parameter int IN_WIDTH     = 14,
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*LANES*IN_WIDTH-1:0]   req_A,
    input  logic [NUM_REQ*LANES*IN_WIDTH-1:0]   req_B,
    output logic                                dp_inReady,
    output logic [LANES*IN_WIDTH-1:0]           dp_A,
    output logic [LANES*IN_WIDTH-1:0]           dp_B,
    input  logic                                dp_outReady,
    input  logic [dp_width(IN_WIDTH)-1:0]       dp_DP,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [dp_width(IN_WIDTH)-1:0]       rsp_DP,
    output logic [$clog2(MAX_INFLIGHT):0]       inflight,
    output logic                                busy,
    output logic                                err_orphan
);

    localparam int OPW   = LANES * IN_WIDTH;
    localparam int DPW   = dp_width(IN_WIDTH);
    localparam int TAG_W = tag_width(NUM_REQ);
    localparam int CW    = $clog2(MAX_INFLIGHT) + 1;

    logic [TAG_W-1:0]   ptr_q, ptr_d;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W-1:0]   cand;
    logic               grant_found;
    logic               accept;
    logic [OPW-1:0]     sel_a, sel_b;

    logic               pop_req, pop_ok, orphan;
    logic               fifo_empty, fifo_full;
    logic [TAG_W-1:0]   fifo_head;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      cnt_d;
    logic [NUM_REQ-1:0] head_oh;

    logic               dp_in_q;
    logic [OPW-1:0]     dp_a_q, dp_b_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DPW-1:0]     rsp_dp_q;
    logic               err_q;

    sched_state_e       state_q, state_d;

    // Round-robin search starting at the pointer, wrapping past the last requester.
    always_comb begin
        int idx;
        idx         = 0;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = TAG_W'(idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // No acceptance while full, even if a result pops in the same cycle.
    assign accept  = reset && enable && grant_found && !fifo_full;
    assign pop_req = enable && dp_outReady;
    assign pop_ok  = pop_req && !fifo_empty;
    assign orphan  = pop_req && fifo_empty;

    // Grant strobe, operand mux, result owner decode and pointer advance.
    always_comb begin
        req_ready = '0;
        head_oh   = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_ready[r] = accept && (grant_idx == TAG_W'(r));
            head_oh[r]   = (fifo_head == TAG_W'(r));
            if (grant_idx == TAG_W'(r)) begin
                sel_a = req_A[r*OPW +: OPW];
                sel_b = req_B[r*OPW +: OPW];
            end
        end
        ptr_d = ptr_q;
        if (accept) ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
    end

    dp_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (accept),
        .push_data_i (grant_idx),
        .pop_i       (pop_ok),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Issue side: register the winner's operands; operands hold between issues.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_in_q <= 1'b0;
            dp_a_q  <= '0;
            dp_b_q  <= '0;
            ptr_q   <= '0;
        end else begin
            dp_in_q <= accept;
            ptr_q   <= ptr_d;
            if (accept) begin
                dp_a_q <= sel_a;
                dp_b_q <= sel_b;
            end
        end
    end

    // Return side: route the engine result to the head tag's owner; flag orphans.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= '0;
            rsp_dp_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= pop_ok ? head_oh : '0;
            if (pop_ok) rsp_dp_q <= dp_DP;
            if (orphan) err_q <= 1'b1;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next occupancy state follows the count the FIFO will hold after this edge.
    always_comb begin
        cnt_d = fifo_count + CW'(accept) - CW'(pop_ok);
        if (cnt_d == '0)                     state_d = ST_IDLE;
        else if (cnt_d == CW'(MAX_INFLIGHT)) state_d = ST_FULL;
        else                                 state_d = ST_RUN;
    end

    // Outputs derived from occupancy state.
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    assign inflight   = fifo_count;
    assign dp_inReady = dp_in_q;
    assign dp_A       = dp_a_q;
    assign dp_B       = dp_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_DP     = rsp_dp_q;
    assign err_orphan = err_q;

endmodule

// File: tb/tb_dotproduct_16_scheduler.sv
// Directed bench for dotproduct_16_scheduler with a queue-based reference model.
module tb_dotproduct_16_scheduler;

    localparam int IW   = 14;
    localparam int NR   = 4;
    localparam int MAXF = 8;
    localparam int OPW  = 16 * IW;
    localparam int DPW  = 2 * IW + 4;

    logic                clk;
    logic                reset;
    logic                enable;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_ready;
    logic [NR*OPW-1:0]   req_A, req_B;
    logic                dp_inReady;
    logic [OPW-1:0]      dp_A, dp_B;
    logic                dp_outReady;
    logic [DPW-1:0]      dp_DP;
    logic [NR-1:0]       rsp_valid;
    logic [DPW-1:0]      rsp_DP;
    logic [3:0]          inflight;
    logic                busy;
    logic                err_orphan;

    dotproduct_16_scheduler #(
        .IN_WIDTH(IW), .NUM_REQ(NR), .MAX_INFLIGHT(MAXF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B),
        .dp_inReady(dp_inReady), .dp_A(dp_A), .dp_B(dp_B),
        .dp_outReady(dp_outReady), .dp_DP(dp_DP),
        .rsp_valid(rsp_valid), .rsp_DP(rsp_DP),
        .inflight(inflight), .busy(busy), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: outstanding owners in issue order, pointer, expected registers.
    int           mq[$];
    int           mp;
    bit           m_err;
    bit           e_in;
    logic [OPW-1:0] e_a, e_b;
    logic [NR-1:0]  e_rv;
    logic [DPW-1:0] e_rd;
    logic [NR-1:0]  e_ready;
    int           cyc;
    int           g, c, h;

    // Observed DUT events for the directed literal checks.
    int g_idx[$], g_cyc[$], in_cyc[$], r_oh[$], r_cyc[$], r_dat[$];

    function automatic int oh2i(input logic [NR-1:0] v);
        int n, r;
        n = 0; r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) begin n++; r = i; end
        return (n == 1) ? r : -2;
    endfunction

    function automatic int qi(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -999;
    endfunction

    // Mid-cycle compare of every output against the model, then advance the model.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_dp_inReady", dp_inReady, 0);
            chk("rst_dp_A", dp_A, 0);
            chk("rst_dp_B", dp_B, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_DP", rsp_DP, 0);
            chk("rst_inflight", inflight, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err_orphan", err_orphan, 0);
            mq.delete(); mp = 0; m_err = 0; e_in = 0;
            e_a = '0; e_b = '0; e_rv = '0; e_rd = '0;
        end else begin
            g = -1; e_ready = '0;
            if (enable && mq.size() < MAXF) begin
                for (int k = 0; k < NR; k++) begin
                    c = (mp + k) % NR;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            if (g >= 0) e_ready[g] = 1'b1;

            chk("req_ready", req_ready, e_ready);
            chk("dp_inReady", dp_inReady, e_in);
            chk("dp_A", dp_A, e_a);
            chk("dp_B", dp_B, e_b);
            chk("rsp_valid", rsp_valid, e_rv);
            if (e_rv != '0) chk("rsp_DP", rsp_DP, e_rd);
            chk("inflight", inflight, mq.size());
            chk("busy", busy, mq.size() != 0);
            chk("err_orphan", err_orphan, m_err);

            if (req_ready != '0) begin g_idx.push_back(oh2i(req_ready)); g_cyc.push_back(cyc); end
            if (dp_inReady) in_cyc.push_back(cyc);
            if (rsp_valid != '0) begin
                r_oh.push_back(int'(rsp_valid)); r_dat.push_back(int'(rsp_DP)); r_cyc.push_back(cyc);
            end

            if (enable) begin
                e_rv = '0;
                if (dp_outReady) begin
                    if (mq.size() > 0) begin
                        h = mq.pop_front();
                        e_rv[h] = 1'b1;
                        e_rd = dp_DP;
                    end else m_err = 1;
                end
                e_in = (g >= 0);
                if (g >= 0) begin
                    mq.push_back(g);
                    mp = (g + 1) % NR;
                    e_a = req_A[g*OPW +: OPW];
                    e_b = req_B[g*OPW +: OPW];
                end
            end else begin
                e_in = 0;
                e_rv = '0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR*16; i++) begin
            req_A[i*IW +: IW] = IW'($urandom);
            req_B[i*IW +: IW] = IW'($urandom);
        end
    endtask

    task automatic clear_logs();
        g_idx.delete(); g_cyc.delete(); in_cyc.delete();
        r_oh.delete(); r_cyc.delete(); r_dat.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic pop_n(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            dp_outReady = 1'b1;
            dp_DP = DPW'(base + k * 1000 - 3);
            tick(1);
        end
        dp_outReady = 1'b0;
    endtask

    int exp_fair[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_drain[8] = '{2, 4, 8, 1, 2, 4, 8, 1};
    int exp_stall[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        reset = 1'b0; enable = 1'b0; req_valid = '0;
        req_A = '0; req_B = '0; dp_outReady = 1'b0; dp_DP = '0;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("idle_inflight", inflight, 0);
        chk("idle_busy", busy, 0);

        // Single request, engine latency 6.
        rand_ops(); clear_logs();
        enable = 1'b1; req_valid = 4'b0100;
        tick(1);
        req_valid = '0;
        chk("t1_inflight_1", inflight, 1);
        tick(6);
        dp_outReady = 1'b1; dp_DP = 32'd123;
        tick(1);
        dp_outReady = 1'b0;
        tick(2);
        chk("t1_grant_cnt", g_idx.size(), 1);
        chk("t1_grant_idx", qi(g_idx, 0), 2);
        chk("t1_issue_lat", qi(in_cyc, 0) - qi(g_cyc, 0), 1);
        chk("t1_rsp_lat", qi(r_cyc, 0) - qi(g_cyc, 0), 8);
        chk("t1_rsp_oh", qi(r_oh, 0), 4);
        chk("t1_rsp_dat", qi(r_dat, 0), 123);
        chk("t1_inflight_0", inflight, 0);

        // Fairness from pointer 0, then fill to full, one pop, one extra accept.
        do_reset(); clear_logs(); rand_ops();
        req_valid = 4'hF;
        tick(8);
        chk("t2_grant_cnt", g_idx.size(), 8);
        for (int i = 0; i < 8; i++) chk("t2_grant_order", qi(g_idx, i), exp_fair[i]);
        chk("t2_full_inflight", inflight, 8);
        chk("t2_full_ready", req_ready, 0);
        tick(2);
        chk("t2_full_nogrant", g_idx.size(), 8);
        chk("t2_full_busy", busy, 1);
        dp_outReady = 1'b1; dp_DP = 32'd77;
        tick(1);
        dp_outReady = 1'b0;
        tick(2);
        req_valid = '0;
        chk("t2_extra_cnt", g_idx.size(), 9);
        chk("t2_extra_idx", qi(g_idx, 8), 0);
        chk("t2_extra_cyc", qi(g_cyc, 8), qi(r_cyc, 0));
        chk("t2_pop_oh", qi(r_oh, 0), 1);
        chk("t2_pop_dat", qi(r_dat, 0), 77);
        pop_n(8, 0);
        tick(2);
        chk("t2_drained", inflight, 0);
        for (int i = 0; i < 8; i++) chk("t2_drain_owner", qi(r_oh, i + 1), exp_drain[i]);

        // Routing of interleaved grants 2, 0, 3.
        clear_logs(); rand_ops();
        req_valid = 4'b0100; tick(1);
        req_valid = 4'b0001; tick(1);
        req_valid = 4'b1000; tick(1);
        req_valid = '0;      tick(2);
        dp_outReady = 1'b1;
        dp_DP = -32'sd5;   tick(1);
        dp_DP = 32'd1000;  tick(1);
        dp_DP = 32'd0;     tick(1);
        dp_outReady = 1'b0;
        tick(2);
        chk("t3_oh0", qi(r_oh, 0), 4);
        chk("t3_dat0", qi(r_dat, 0), -5);
        chk("t3_oh1", qi(r_oh, 1), 1);
        chk("t3_dat1", qi(r_dat, 1), 1000);
        chk("t3_oh2", qi(r_oh, 2), 8);
        chk("t3_dat2", qi(r_dat, 2), 0);

        // Orphan result, then reset with three in flight.
        clear_logs();
        dp_outReady = 1'b1; dp_DP = 32'd55;
        tick(1);
        dp_outReady = 1'b0;
        tick(1);
        chk("t4_orphan_err", err_orphan, 1);
        chk("t4_orphan_norsp", r_oh.size(), 0);
        chk("t4_orphan_inflight", inflight, 0);
        req_valid = 4'b0111;
        tick(3);
        req_valid = '0;
        chk("t4_inflight3", inflight, 3);
        reset = 1'b0;
        #1;
        chk("t4_async_inReady", dp_inReady, 0);
        chk("t4_async_dpA", dp_A, 0);
        chk("t4_async_inflight", inflight, 0);
        chk("t4_async_busy", busy, 0);
        chk("t4_async_err", err_orphan, 0);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("t4_post_inflight", inflight, 0);
        clear_logs();
        dp_outReady = 1'b1;
        tick(1);
        dp_outReady = 1'b0;
        tick(1);
        chk("t4_late_orphan", err_orphan, 1);
        chk("t4_late_norsp", r_oh.size(), 0);

        // Stall during RUN, then resume.
        do_reset(); clear_logs(); rand_ops();
        req_valid = 4'hF;
        tick(3);
        enable = 1'b0; dp_outReady = 1'b1; dp_DP = 32'd9;
        tick(5);
        chk("t5_stall_grants", g_idx.size(), 3);
        chk("t5_stall_inflight", inflight, 3);
        chk("t5_stall_inReady", dp_inReady, 0);
        chk("t5_stall_err", err_orphan, 0);
        enable = 1'b1; dp_outReady = 1'b0;
        tick(3);
        req_valid = '0;
        for (int i = 0; i < 6; i++) chk("t5_grant_order", qi(g_idx, i), exp_stall[i]);
        chk("t5_inflight", inflight, 6);
        pop_n(6, 11);
        tick(2);
        chk("t5_drained", inflight, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
